vector_mem_access: RTL and testbench
====================================

# vector_mem_access

Vector load/store sequencer sitting between the vector execution stage and the word-addressed data memory. It accepts one vector request per handshake. It then drives the memory's read address, write address, write enable and write data one lane per cycle. Load lanes are collected into a single wide response, and store completion is acknowledged with a response handshake.

## Interface
- LANES, 4, number of vector lanes (≥2)
- DATA_WIDTH, 32, bits per lane / memory word
- ADDRESS_WIDTH, 32, word address width

- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- reqValid  input  1  request present
- reqReady  output  1  block can accept a request (high only in IDLE)
- reqWrite  input  1  1 = store, 0 = load
- reqBaseAddress  input  ADDRESS_WIDTH  word address of lane 0
- reqStride  input  ADDRESS_WIDTH  word stride between lanes (present only with VMA_STRIDE_EN)
- reqData  input  LANES*DATA_WIDTH  store data; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- memReadAddress  output  ADDRESS_WIDTH  to memory read port
- memWriteAddress  output  ADDRESS_WIDTH  to memory write port
- memWriteEnable  output  1  to memory write enable
- memInputData  output  DATA_WIDTH  to memory write data
- memOutputData  input  DATA_WIDTH  from memory, combinational read of memReadAddress
- respValid  output  1  response present
- respReady  input  1  consumer accepts response
- respData  output  LANES*DATA_WIDTH  load result in the same lane packing as reqData; all zero for stores

## Operation
- States: IDLE, LOAD, STORE, RESP.
- IDLE: reqReady=1. On reqValid&&reqReady, the block latches reqWrite, reqBaseAddress, reqStride and reqData. It clears laneCount and the lane address register, then goes to STORE if reqWrite is 1, else LOAD. Request inputs are ignored outside the handshake cycle.
- Lane address: addr(i) = reqBaseAddress + i*stride, computed as an incremental add, truncated mod 2^ADDRESS_WIDTH. Wrap-around past the top address is legal and silent.
- LOAD: memReadAddress=addr(laneCount). memOutputData is captured into lane laneCount at the edge. laneCount increments. After lane LANES-1 the state goes to RESP.
- STORE: memWriteAddress=addr(laneCount), memInputData=lane laneCount of latched data, memWriteEnable=1. laneCount increments. After lane LANES-1 the state goes to RESP.
- RESP: respValid=1 and respData is held stable. On respReady the state goes to IDLE. A new request cannot be accepted in the same cycle the response is taken.
- Lanes are issued strictly in order 0..LANES-1; no lane is skipped or repeated.
- Outside LOAD/STORE, memWriteEnable=0 and both memory addresses are 0.

## Timing
- Handshake at edge N: lane 0 is on the memory bus during cycle N+1, and lane i during cycle N+1+i.
- respValid rises in cycle N+LANES+1. Minimum request-to-request period is LANES+2 cycles.
- Store: the write to lane i commits at the rising edge ending cycle N+1+i.
- Load data is sampled at the same edge its address is driven (zero-latency memory read).
- Reset values:
  - state is IDLE, so reqReady=1 from the first cycle after reset.
  - respValid, memWriteEnable, memReadAddress, memWriteAddress, memInputData, respData and laneCount are 0.
- Reset mid-operation: the block returns to IDLE at that edge and memWriteEnable is low in the following cycle. Unissued store lanes are never written and no response is produced. Partial load data is cleared.
- respValid stays high with respData unchanged until respReady; respReady is a don't-care when respValid=0.

## Configuration
- VMA_STRIDE_EN defined: the reqStride port exists and lanes use the latched stride. A stride of 0 repeats the base address for every lane, which is legal.
- VMA_STRIDE_EN undefined: the reqStride port is absent and the stride is fixed at 1 (unit-stride contiguous access). All timing is identical.

## Structure
- Package vector_mem_pkg holds the state enum (IDLE, LOAD, STORE, RESP), the LANES default, and the lane-slice helper constants.
- Sub-module vma_lane_addr_gen holds the lane address register: load on start, add stride on step, with an ADDRESS_WIDTH wrap. The sequencer FSM, lane counter and data registers stay in the top.

## Test plan
- Load, base 0x10, LANES=4, memory[0x10..0x13]=1,2,3,4 → respValid at N+5, respData lanes 0..3 = 1,2,3,4, reqReady low for cycles N+1..N+5.
- Store, base 0x20, data lanes 0xA,0xB,0xC,0xD → memWriteEnable high in cycles N+1..N+4 at addresses 0x20..0x23; a load of 0x20 afterwards returns the same data.
- Base 0xFFFFFFFE load (stride 1) → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- With VMA_STRIDE_EN, base 0x40, stride 4 → addresses 0x40, 0x44, 0x48, 0x4C. With stride 0, all four lanes read 0x40.
- respReady held low for 10 cycles → respValid and respData stable throughout. After respReady, reqReady=1 the next cycle.
- Reset asserted during store cycle N+2 → only lanes 0 and 1 are written, respValid is never asserted, and reqReady=1 after the reset edge.

Source files
------------

// File: rtl/vector_mem_pkg.sv
// Shared types and defaults for the vector load/store sequencer.
package vector_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } vma_state_e;

  localparam int LANES_DEFAULT         = 4;
  localparam int DATA_WIDTH_DEFAULT    = 32;
  localparam int ADDRESS_WIDTH_DEFAULT = 32;

  // Lane i of a packed vector occupies [lane_lsb(i) +: data_width].
  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/vector_mem_access_if.sv
// Request, response and memory-port bundle for vector_mem_access.
// reqStride exists only when VMA_STRIDE_EN is defined.
interface vector_mem_access_if
  import vector_mem_pkg::*;
#(
  parameter int LANES         = LANES_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
);
  logic                        reqValid;
  logic                        reqReady;
  logic                        reqWrite;
  logic [ADDRESS_WIDTH-1:0]    reqBaseAddress;
`ifdef VMA_STRIDE_EN
  logic [ADDRESS_WIDTH-1:0]    reqStride;
`endif
  logic [LANES*DATA_WIDTH-1:0] reqData;
  logic [ADDRESS_WIDTH-1:0]    memReadAddress;
  logic [ADDRESS_WIDTH-1:0]    memWriteAddress;
  logic                        memWriteEnable;
  logic [DATA_WIDTH-1:0]       memInputData;
  logic [DATA_WIDTH-1:0]       memOutputData;
  logic                        respValid;
  logic                        respReady;
  logic [LANES*DATA_WIDTH-1:0] respData;

  modport master (
`ifdef VMA_STRIDE_EN
    output reqStride,
`endif
    output reqValid, reqWrite, reqBaseAddress, reqData, memOutputData, respReady,
    input  reqReady, memReadAddress, memWriteAddress, memWriteEnable, memInputData,
    input  respValid, respData
  );

  modport slave (
`ifdef VMA_STRIDE_EN
    input  reqStride,
`endif
    input  reqValid, reqWrite, reqBaseAddress, reqData, memOutputData, respReady,
    output reqReady, memReadAddress, memWriteAddress, memWriteEnable, memInputData,
    output respValid, respData
  );
endinterface

// File: rtl/vma_lane_addr_gen.sv
// Lane address register: loads the base on start, adds the stride on each
// step, wrapping modulo 2^ADDRESS_WIDTH.
module vma_lane_addr_gen #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic [ADDRESS_WIDTH-1:0] stride,
  output logic [ADDRESS_WIDTH-1:0] addr
);

  always_ff @(posedge clk) begin
    if (reset)      addr <= '0;
    else if (start) addr <= base;
    else if (step)  addr <= addr + stride;
  end

endmodule

// File: rtl/vector_mem_access.sv
// Vector load/store sequencer: one lane per cycle to a word-addressed memory.
// Define VMA_STRIDE_EN for a per-request stride; otherwise stride is fixed at 1.
//   state | meaning
//   IDLE  | ready for a request
//   LOAD  | reading lane lane_count into the response vector
//   STORE | writing lane lane_count of the latched data
//   RESP  | holding the response until respReady
module vector_mem_access
  import vector_mem_pkg::*;
#(
  parameter int LANES         = LANES_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  vector_mem_access_if.slave bus
);

  localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW  = LANES * DATA_WIDTH;

  vma_state_e               state, state_next;
  logic [LCW-1:0]           lane_count;
  logic                     is_write;
  logic [VW-1:0]            lane_data;
  logic [ADDRESS_WIDTH-1:0] stride, lane_addr;
  logic [DATA_WIDTH-1:0]    store_lane;
  logic                     accept, lane_last, addr_start, addr_step;

  assign accept    = (state == IDLE) && bus.reqValid;
  assign lane_last = (lane_count == LCW'(LANES - 1));

`ifdef VMA_STRIDE_EN
  logic [ADDRESS_WIDTH-1:0] stride_q;
  always_ff @(posedge clk) begin
    if (reset)       stride_q <= '0;
    else if (accept) stride_q <= bus.reqStride;
  end
  assign stride = stride_q;
`else
  assign stride = ADDRESS_WIDTH'(1);
`endif

  vma_lane_addr_gen #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .start  (addr_start),
    .step   (addr_step),
    .base   (bus.reqBaseAddress),
    .stride (stride),
    .addr   (lane_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // One register serves as store data or load accumulator; respData masks it for stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_count <= '0;
      is_write   <= 1'b0;
      lane_data  <= '0;
    end else if (accept) begin
      lane_count <= '0;
      is_write   <= bus.reqWrite;
      lane_data  <= bus.reqWrite ? bus.reqData : '0;
    end else if (state == LOAD || state == STORE) begin
      lane_count <= lane_last ? '0 : lane_count + LCW'(1);
      if (state == LOAD) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_count == LCW'(i))
            lane_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <= bus.memOutputData;
        end
      end
    end
  end

  always_comb begin
    store_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_count == LCW'(i))
        store_lane = lane_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_next          = state;
    addr_start          = 1'b0;
    addr_step           = 1'b0;
    bus.reqReady        = 1'b0;
    bus.respValid       = 1'b0;
    bus.memReadAddress  = '0;
    bus.memWriteAddress = '0;
    bus.memWriteEnable  = 1'b0;
    bus.memInputData    = '0;
    unique case (state)
      IDLE: begin
        bus.reqReady = 1'b1;
        if (bus.reqValid) begin
          addr_start = 1'b1;
          state_next = bus.reqWrite ? STORE : LOAD;
        end
      end
      LOAD: begin
        bus.memReadAddress = lane_addr;
        addr_step          = 1'b1;
        if (lane_last) state_next = RESP;
      end
      STORE: begin
        bus.memWriteAddress = lane_addr;
        bus.memWriteEnable  = 1'b1;
        bus.memInputData    = store_lane;
        addr_step           = 1'b1;
        if (lane_last) state_next = RESP;
      end
      RESP: begin
        bus.respValid = 1'b1;
        if (bus.respReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.respData = (state == RESP && !is_write) ? lane_data : '0;

endmodule

// File: tb/tb_vector_mem_access.sv
// Directed bench for vector_mem_access; stride vectors are added when
// VMA_STRIDE_EN is defined.
module tb_vector_mem_access;
  import vector_mem_pkg::*;

  localparam int L  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic              write;
    logic [7:0]        hold;
    logic [AW-1:0]     base;
    logic [AW-1:0]     stride;
    logic [L*DW-1:0]   data;
    logic [L*DW-1:0]   resp;
    logic [L-1:0][AW-1:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vector_mem_access_if #(.LANES(L), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();

  vector_mem_access #(.LANES(L), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [256];

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      8'h10: return 32'h1;
      8'h11: return 32'h2;
      8'h12: return 32'h3;
      8'h13: return 32'h4;
      8'hFE: return 32'h55;
      8'hFF: return 32'h66;
      8'h00: return 32'h77;
      8'h01: return 32'h88;
      8'h40: return 32'h1040;
      8'h44: return 32'h1044;
      8'h48: return 32'h1048;
      8'h4C: return 32'h104C;
      default: return 32'hDEAD_0000 + 32'(a);
    endcase
  endfunction

  assign bus.memOutputData = mem[bus.memReadAddress[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
    end else if (bus.memWriteEnable) begin
      mem[bus.memWriteAddress[7:0]] <= bus.memInputData;
    end
  end

  task automatic check(input string name, input logic [L*DW-1:0] act, input logic [L*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.reqValid       = 1'b1;
    bus.reqWrite       = v.write;
    bus.reqBaseAddress = v.base;
    bus.reqData        = v.data;
`ifdef VMA_STRIDE_EN
    bus.reqStride      = v.stride;
`endif
  endtask

  task automatic run_vec(input vec_t v);
    drive_req(v);
    #1;
    check("req_ready_idle", bus.reqReady, 1);
    @(posedge clk); #1;
    // Garbage request held high while busy must be ignored.
    bus.reqWrite       = ~v.write;
    bus.reqBaseAddress = 32'h0BAD_0000;
    bus.reqData        = '1;
    for (int i = 0; i < L; i++) begin
      check("req_ready_busy", bus.reqReady, 0);
      check("resp_valid_busy", bus.respValid, 0);
      if (v.write) begin
        check("store_we", bus.memWriteEnable, 1);
        check("store_addr", bus.memWriteAddress, v.exp_addr[i]);
        check("store_data", bus.memInputData, v.data[i*DW +: DW]);
        check("store_raddr_zero", bus.memReadAddress, 0);
      end else begin
        check("load_addr", bus.memReadAddress, v.exp_addr[i]);
        check("load_we", bus.memWriteEnable, 0);
        check("load_waddr_zero", bus.memWriteAddress, 0);
      end
      @(posedge clk); #1;
    end
    for (int h = 0; h < int'(v.hold); h++) begin
      check("resp_valid_hold", bus.respValid, 1);
      check("resp_data_hold", bus.respData, v.resp);
      check("req_ready_resp", bus.reqReady, 0);
      @(posedge clk); #1;
    end
    bus.respReady = 1'b1;
    #1;
    check("resp_valid", bus.respValid, 1);
    check("resp_data", bus.respData, v.resp);
    check("req_ready_on_take", bus.reqReady, 0);
    @(posedge clk); #1;
    bus.respReady = 1'b0;
    bus.reqValid  = 1'b0;
    check("req_ready_after", bus.reqReady, 1);
    check("resp_valid_after", bus.respValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  vec_t vecs[$];
  vec_t rv;

  initial begin
    bus.reqValid       = 1'b0;
    bus.reqWrite       = 1'b0;
    bus.reqBaseAddress = '0;
    bus.reqData        = '0;
    bus.respReady      = 1'b0;
`ifdef VMA_STRIDE_EN
    bus.reqStride      = 32'h1;
`endif

    vecs.push_back('{write: 1'b0, hold: 8'd0, base: 32'h10, stride: 32'h1,
                     data: '0, resp: 128'h00000004_00000003_00000002_00000001,
                     exp_addr: {32'h13, 32'h12, 32'h11, 32'h10}});
    vecs.push_back('{write: 1'b1, hold: 8'd0, base: 32'h20, stride: 32'h1,
                     data: 128'h0000000D_0000000C_0000000B_0000000A, resp: '0,
                     exp_addr: {32'h23, 32'h22, 32'h21, 32'h20}});
    vecs.push_back('{write: 1'b0, hold: 8'd0, base: 32'h20, stride: 32'h1,
                     data: '0, resp: 128'h0000000D_0000000C_0000000B_0000000A,
                     exp_addr: {32'h23, 32'h22, 32'h21, 32'h20}});
    vecs.push_back('{write: 1'b0, hold: 8'd0, base: 32'hFFFF_FFFE, stride: 32'h1,
                     data: '0, resp: 128'h00000088_00000077_00000066_00000055,
                     exp_addr: {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}});
    vecs.push_back('{write: 1'b0, hold: 8'd10, base: 32'h10, stride: 32'h1,
                     data: '0, resp: 128'h00000004_00000003_00000002_00000001,
                     exp_addr: {32'h13, 32'h12, 32'h11, 32'h10}});
`ifdef VMA_STRIDE_EN
    vecs.push_back('{write: 1'b0, hold: 8'd0, base: 32'h40, stride: 32'h4,
                     data: '0, resp: 128'h0000104C_00001048_00001044_00001040,
                     exp_addr: {32'h4C, 32'h48, 32'h44, 32'h40}});
    vecs.push_back('{write: 1'b0, hold: 8'd0, base: 32'h40, stride: 32'h0,
                     data: '0, resp: 128'h00001040_00001040_00001040_00001040,
                     exp_addr: {32'h40, 32'h40, 32'h40, 32'h40}});
`endif

    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_init = 1'b0;
    #1;
    check("rst_req_ready", bus.reqReady, 1);
    check("rst_resp_valid", bus.respValid, 0);
    check("rst_we", bus.memWriteEnable, 0);
    check("rst_raddr", bus.memReadAddress, 0);
    check("rst_waddr", bus.memWriteAddress, 0);
    check("rst_wdata", bus.memInputData, 0);
    check("rst_resp_data", bus.respData, 0);
    @(posedge clk); #1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset during the second store lane: lanes 0 and 1 commit, nothing after.
    rv = '{write: 1'b1, hold: 8'd0, base: 32'h30, stride: 32'h1,
           data: 128'h000000E4_000000E3_000000E2_000000E1, resp: '0,
           exp_addr: {32'h33, 32'h32, 32'h31, 32'h30}};
    drive_req(rv);
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    check("rst_mid_lane0_we", bus.memWriteEnable, 1);
    check("rst_mid_lane0_addr", bus.memWriteAddress, 32'h30);
    @(posedge clk); #1;
    check("rst_mid_lane1_addr", bus.memWriteAddress, 32'h31);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_we_low", bus.memWriteEnable, 0);
    check("rst_mid_req_ready", bus.reqReady, 1);
    for (int c = 0; c < 6; c++) begin
      check("rst_mid_no_resp", bus.respValid, 0);
      check("rst_mid_no_write", bus.memWriteEnable, 0);
      @(posedge clk); #1;
    end
    check("rst_mid_mem30", mem[8'h30], 32'hE1);
    check("rst_mid_mem31", mem[8'h31], 32'hE2);
    check("rst_mid_mem32", mem[8'h32], 32'hDEAD_0032);
    check("rst_mid_mem33", mem[8'h33], 32'hDEAD_0033);

    rv = '{write: 1'b0, hold: 8'd0, base: 32'h30, stride: 32'h1,
           data: '0, resp: 128'hDEAD0033_DEAD0032_000000E2_000000E1,
           exp_addr: {32'h33, 32'h32, 32'h31, 32'h30}};
    run_vec(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
